// File: rtl/mem_responder.sv
// mem_responder: multi-channel memory responder for the GPU channel read/write protocol.
// Every channel has an independent read FSM and write FSM (IDLE -> BUSY -> RESP) using a
// four-phase valid/ready handshake with a fixed latency from acceptance to ready.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   load_en/addr/data   - preload port, writes one word per edge (wins every collision)
//   mem_read_valid      - per-channel read request
//   mem_read_address    - per-channel read address
//   mem_read_ready      - per-channel read response, held until valid drops
//   mem_read_data       - per-channel read data, stable while ready is high
//   mem_write_valid     - per-channel write request
//   mem_write_address   - per-channel write address
//   mem_write_data      - per-channel write data
//   mem_write_ready     - per-channel write completion, held until valid drops
module mem_responder #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITABLE      = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     load_en,
    input  logic [ADDR_BITS-1:0]                     load_addr,
    input  logic [DATA_BITS-1:0]                     load_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    output logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int unsigned Depth   = 2 ** ADDR_BITS;
    localparam int unsigned MaxLat  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                    : WRITE_LATENCY;
    // Counter only ever holds LATENCY-1.
    localparam int unsigned CntBits = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntBits-1:0] RdInit = CntBits'(READ_LATENCY - 1);
    localparam logic [CntBits-1:0] WrInit = CntBits'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // Storage has no reset; contents survive reset by design.
    logic [DATA_BITS-1:0] mem_q [Depth];

    state_e rd_state_q [NUM_CHANNELS];
    state_e rd_state_d [NUM_CHANNELS];
    state_e wr_state_q [NUM_CHANNELS];
    state_e wr_state_d [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0][CntBits-1:0]   rd_cnt_q, rd_cnt_d;
    logic [NUM_CHANNELS-1:0][CntBits-1:0]   wr_cnt_q, wr_cnt_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic [NUM_CHANNELS-1:0]                rd_ready_q, rd_ready_d;
    logic [NUM_CHANNELS-1:0]                wr_ready_q, wr_ready_d;
    logic [NUM_CHANNELS-1:0]                wr_commit;

    // Read FSMs
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            rd_state_d[ch] = rd_state_q[ch];
            rd_cnt_d[ch]   = rd_cnt_q[ch];
            rd_addr_d[ch]  = rd_addr_q[ch];
            rd_data_d[ch]  = rd_data_q[ch];
            rd_ready_d[ch] = rd_ready_q[ch];
            unique case (rd_state_q[ch])
                StIdle: begin
                    if (mem_read_valid[ch]) begin
                        rd_state_d[ch] = StBusy;
                        rd_addr_d[ch]  = mem_read_address[ch];
                        rd_cnt_d[ch]   = RdInit;
                    end
                end
                StBusy: begin
                    // Abort outranks completion.
                    if (!mem_read_valid[ch]) begin
                        rd_state_d[ch] = StIdle;
                        rd_cnt_d[ch]   = '0;
                    end else if (rd_cnt_q[ch] == '0) begin
                        rd_state_d[ch] = StResp;
                        rd_ready_d[ch] = 1'b1;
                        // Pre-edge storage value: a same-edge write is not visible here.
                        rd_data_d[ch]  = mem_q[rd_addr_q[ch]];
                    end else begin
                        rd_cnt_d[ch] = rd_cnt_q[ch] - 1'b1;
                    end
                end
                StResp: begin
                    if (!mem_read_valid[ch]) begin
                        rd_state_d[ch] = StIdle;
                        rd_ready_d[ch] = 1'b0;
                    end
                end
                default: begin
                    rd_state_d[ch] = StIdle;
                    rd_ready_d[ch] = 1'b0;
                end
            endcase
        end
    end

    // Write FSMs; with WRITABLE=0 they never leave IDLE.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            wr_state_d[ch] = wr_state_q[ch];
            wr_cnt_d[ch]   = wr_cnt_q[ch];
            wr_addr_d[ch]  = wr_addr_q[ch];
            wr_data_d[ch]  = wr_data_q[ch];
            wr_ready_d[ch] = wr_ready_q[ch];
            wr_commit[ch]  = 1'b0;
            if (WRITABLE != 0) begin
                unique case (wr_state_q[ch])
                    StIdle: begin
                        if (mem_write_valid[ch]) begin
                            wr_state_d[ch] = StBusy;
                            wr_addr_d[ch]  = mem_write_address[ch];
                            wr_data_d[ch]  = mem_write_data[ch];
                            wr_cnt_d[ch]   = WrInit;
                        end
                    end
                    StBusy: begin
                        if (!mem_write_valid[ch]) begin
                            wr_state_d[ch] = StIdle;
                            wr_cnt_d[ch]   = '0;
                        end else if (wr_cnt_q[ch] == '0) begin
                            wr_state_d[ch] = StResp;
                            wr_ready_d[ch] = 1'b1;
                            wr_commit[ch]  = 1'b1;
                        end else begin
                            wr_cnt_d[ch] = wr_cnt_q[ch] - 1'b1;
                        end
                    end
                    StResp: begin
                        if (!mem_write_valid[ch]) begin
                            wr_state_d[ch] = StIdle;
                            wr_ready_d[ch] = 1'b0;
                        end
                    end
                    default: begin
                        wr_state_d[ch] = StIdle;
                        wr_ready_d[ch] = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                rd_state_q[ch] <= StIdle;
                wr_state_q[ch] <= StIdle;
            end
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                rd_state_q[ch] <= rd_state_d[ch];
                wr_state_q[ch] <= wr_state_d[ch];
            end
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Later assignments win: ascending channel order gives the highest index priority,
    // and the preload port is applied last so it beats every channel.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (wr_commit[ch] && !reset) begin
                mem_q[wr_addr_q[ch]] <= wr_data_q[ch];
            end
        end
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign mem_read_ready  = rd_ready_q;
    assign mem_read_data   = rd_data_q;
    assign mem_write_ready = wr_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int NCH = 4;
    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int RL  = 2;
    localparam int WL  = 2;

    typedef enum logic [1:0] {OpLoad, OpRead, OpWrite} op_e;
    typedef struct {
        op_e         op;
        int          ch;
        logic [7:0]  addr;
        logic [7:0]  data;  // write/preload data, or expected read data
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    logic                     load_en;
    logic [AB-1:0]            load_addr;
    logic [DB-1:0]            load_data;
    logic [NCH-1:0]           rd_valid;
    logic [NCH-1:0][AB-1:0]   rd_addr;
    logic [NCH-1:0]           rd_ready;
    logic [NCH-1:0][DB-1:0]   rd_data;
    logic [NCH-1:0]           wr_valid;
    logic [NCH-1:0][AB-1:0]   wr_addr;
    logic [NCH-1:0][DB-1:0]   wr_data;
    logic [NCH-1:0]           wr_ready;

    logic                     ro_load_en;
    logic [AB-1:0]            ro_load_addr;
    logic [DB-1:0]            ro_load_data;
    logic [NCH-1:0]           ro_rd_valid;
    logic [NCH-1:0][AB-1:0]   ro_rd_addr;
    logic [NCH-1:0]           ro_rd_ready;
    logic [NCH-1:0][DB-1:0]   ro_rd_data;
    logic [NCH-1:0]           ro_wr_valid;
    logic [NCH-1:0][AB-1:0]   ro_wr_addr;
    logic [NCH-1:0][DB-1:0]   ro_wr_data;
    logic [NCH-1:0]           ro_wr_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITABLE(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .mem_read_valid(rd_valid), .mem_read_address(rd_addr),
        .mem_read_ready(rd_ready), .mem_read_data(rd_data),
        .mem_write_valid(wr_valid), .mem_write_address(wr_addr),
        .mem_write_data(wr_data), .mem_write_ready(wr_ready)
    );

    mem_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NCH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITABLE(0)
    ) u_ro (
        .clk(clk), .reset(reset),
        .load_en(ro_load_en), .load_addr(ro_load_addr), .load_data(ro_load_data),
        .mem_read_valid(ro_rd_valid), .mem_read_address(ro_rd_addr),
        .mem_read_ready(ro_rd_ready), .mem_read_data(ro_rd_data),
        .mem_write_valid(ro_wr_valid), .mem_write_address(ro_wr_addr),
        .mem_write_data(ro_wr_data), .mem_write_ready(ro_wr_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Full handshake: checks latency edge, data, hold while valid, and release.
    task automatic do_read(input int ch, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_valid[ch] = 1'b1; rd_addr[ch] = a;
        @(negedge clk);
        rd_addr[ch] = ~a;  // must be ignored once accepted
        repeat (RL - 1) @(negedge clk);
        check("rd_not_yet", 32'(rd_ready[ch]), 32'd0);
        @(negedge clk);
        check("rd_ready", 32'(rd_ready[ch]), 32'd1);
        check("rd_data", 32'(rd_data[ch]), 32'(exp));
        @(negedge clk);
        check("rd_hold", 32'(rd_ready[ch]), 32'd1);
        rd_valid[ch] = 1'b0;
        @(negedge clk);
        check("rd_release", 32'(rd_ready[ch]), 32'd0);
    endtask

    task automatic do_write(input int ch, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_valid[ch] = 1'b1; wr_addr[ch] = a; wr_data[ch] = d;
        @(negedge clk);
        wr_addr[ch] = ~a; wr_data[ch] = ~d;
        repeat (WL - 1) @(negedge clk);
        check("wr_not_yet", 32'(wr_ready[ch]), 32'd0);
        @(negedge clk);
        check("wr_ready", 32'(wr_ready[ch]), 32'd1);
        @(negedge clk);
        check("wr_hold", 32'(wr_ready[ch]), 32'd1);
        wr_valid[ch] = 1'b0;
        @(negedge clk);
        check("wr_release", 32'(wr_ready[ch]), 32'd0);
    endtask

    task automatic ro_read(input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        ro_rd_valid[0] = 1'b1; ro_rd_addr[0] = a;
        repeat (RL + 1) @(negedge clk);
        check("ro_rd_ready", 32'(ro_rd_ready[0]), 32'd1);
        check("ro_rd_data", 32'(ro_rd_data[0]), 32'(exp));
        ro_rd_valid[0] = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{OpLoad,  0, 8'h10, 8'hA5};
        vecs[1]  = '{OpRead,  0, 8'h10, 8'hA5};
        vecs[2]  = '{OpWrite, 1, 8'h20, 8'h3C};
        vecs[3]  = '{OpRead,  2, 8'h20, 8'h3C};
        vecs[4]  = '{OpLoad,  0, 8'h30, 8'h5A};
        vecs[5]  = '{OpRead,  3, 8'h30, 8'h5A};
        vecs[6]  = '{OpWrite, 3, 8'h30, 8'hC3};
        vecs[7]  = '{OpRead,  0, 8'h30, 8'hC3};
        vecs[8]  = '{OpLoad,  0, 8'hFF, 8'h81};
        vecs[9]  = '{OpRead,  1, 8'hFF, 8'h81};
        vecs[10] = '{OpWrite, 0, 8'h00, 8'h7E};
        vecs[11] = '{OpRead,  3, 8'h00, 8'h7E};

        reset = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
        ro_load_en = 1'b0; ro_load_addr = '0; ro_load_data = '0;
        ro_rd_valid = '0; ro_rd_addr = '0; ro_wr_valid = '0; ro_wr_addr = '0; ro_wr_data = '0;
        repeat (3) @(negedge clk);

        check("reset_rd_ready", 32'(rd_ready), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_ro_wr_ready", 32'(ro_wr_ready), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OpLoad:  preload(vecs[i].addr, vecs[i].data);
                OpRead:  do_read(vecs[i].ch, vecs[i].addr, vecs[i].data);
                default: do_write(vecs[i].ch, vecs[i].addr, vecs[i].data);
            endcase
        end

        // Channels 0 and 3 commit to 0x05 on the same edge: channel 3 wins.
        @(negedge clk);
        wr_valid[0] = 1'b1; wr_addr[0] = 8'h05; wr_data[0] = 8'h11;
        wr_valid[3] = 1'b1; wr_addr[3] = 8'h05; wr_data[3] = 8'h22;
        repeat (WL + 1) @(negedge clk);
        check("coll_ready", 32'({wr_ready[3], wr_ready[0]}), 32'h3);
        wr_valid = '0;
        @(negedge clk);
        do_read(1, 8'h05, 8'h22);

        // Same collision plus preload on the commit edge: preload wins.
        @(negedge clk);
        wr_valid[0] = 1'b1; wr_addr[0] = 8'h05; wr_data[0] = 8'h11;
        wr_valid[3] = 1'b1; wr_addr[3] = 8'h05; wr_data[3] = 8'h22;
        repeat (WL) @(negedge clk);
        load_en = 1'b1; load_addr = 8'h05; load_data = 8'h77;
        @(negedge clk);
        load_en = 1'b0;
        check("coll_load_ready", 32'({wr_ready[3], wr_ready[0]}), 32'h3);
        wr_valid = '0;
        @(negedge clk);
        do_read(2, 8'h05, 8'h77);

        // Read latch and write commit to one address on the same edge: old word returned.
        preload(8'h40, 8'h01);
        @(negedge clk);
        rd_valid[0] = 1'b1; rd_addr[0] = 8'h40;
        wr_valid[1] = 1'b1; wr_addr[1] = 8'h40; wr_data[1] = 8'h02;
        repeat (RL + 1) @(negedge clk);
        check("rw_same_edge_data", 32'(rd_data[0]), 32'h01);
        rd_valid = '0; wr_valid = '0;
        @(negedge clk);
        do_read(3, 8'h40, 8'h02);

        // All four channels read at once: readies rise together.
        preload(8'h50, 8'hE0);
        preload(8'h51, 8'hE1);
        preload(8'h52, 8'hE2);
        preload(8'h53, 8'hE3);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            rd_valid[c] = 1'b1; rd_addr[c] = 8'(8'h50 + c);
        end
        repeat (RL) @(negedge clk);
        check("all_rd_not_yet", 32'(rd_ready), 32'h0);
        @(negedge clk);
        check("all_rd_ready", 32'(rd_ready), 32'hF);
        check("all_rd_data", 32'(rd_data), 32'hE3E2E1E0);
        rd_valid = '0;
        @(negedge clk);

        // Write abort during BUSY: no ready, no commit.
        preload(8'h60, 8'h99);
        @(negedge clk);
        wr_valid[2] = 1'b1; wr_addr[2] = 8'h60; wr_data[2] = 8'h44;
        @(negedge clk);
        wr_valid[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wr_abort_no_ready", 32'(wr_ready[2]), 32'd0);
        end
        do_read(1, 8'h60, 8'h99);
        do_write(2, 8'h60, 8'h45);
        do_read(1, 8'h60, 8'h45);

        // Read abort during BUSY.
        @(negedge clk);
        rd_valid[3] = 1'b1; rd_addr[3] = 8'h60;
        @(negedge clk);
        rd_valid[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rd_abort_no_ready", 32'(rd_ready[3]), 32'd0);
        end

        // Reset while in RESP.
        @(negedge clk);
        rd_valid[0] = 1'b1; rd_addr[0] = 8'h10;
        repeat (RL + 1) @(negedge clk);
        check("pre_reset_ready", 32'(rd_ready[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_resp_ready", 32'(rd_ready[0]), 32'd0);
        check("reset_resp_data", 32'(rd_data[0]), 32'd0);
        reset = 1'b0; rd_valid[0] = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(rd_ready[0]), 32'd0);

        // Reset while a write is in BUSY: nothing committed; storage survives reset.
        preload(8'h70, 8'h12);
        @(negedge clk);
        wr_valid[1] = 1'b1; wr_addr[1] = 8'h70; wr_data[1] = 8'hEE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; wr_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr_no_ready", 32'(wr_ready[1]), 32'd0);
        do_read(0, 8'h70, 8'h12);
        do_read(2, 8'h10, 8'hA5);

        // WRITABLE=0 instance: write held 10 cycles never completes.
        @(negedge clk);
        ro_load_en = 1'b1; ro_load_addr = 8'h08; ro_load_data = 8'h5C;
        @(negedge clk);
        ro_load_en = 1'b0;
        ro_wr_valid[0] = 1'b1; ro_wr_addr[0] = 8'h08; ro_wr_data[0] = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("ro_wr_ready_low", 32'(ro_wr_ready), 32'd0);
        end
        ro_wr_valid = '0;
        ro_read(8'h08, 8'h5C);
        @(negedge clk);
        ro_load_en = 1'b1; ro_load_addr = 8'h08; ro_load_data = 8'h6D;
        @(negedge clk);
        ro_load_en = 1'b0;
        ro_read(8'h08, 8'h6D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
